// File: rtl/fir_ahb_pkg.sv
// Shared constants, state encoding and helpers for the AHB-lite FIR filter.
// Build option FIR_ROUND_EN (see fir_mac_core) does not change anything here.
package fir_ahb_pkg;

  localparam int OFF_STATUS  = 'h0;
  localparam int OFF_RESULT  = 'h2;
  localparam int OFF_SAMPLE  = 'h4;
  localparam int OFF_CONFIRM = 'h6;
  localparam int OFF_COEFF0  = 'h8;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    MAC,
    DONE
  } fir_state_e;

  function automatic int acc_width(input int n);
    return 32 + $clog2(n);
  endfunction

  // Byte-lane merge: lane[0] covers [7:0], lane[1] covers [15:8].
  function automatic logic [15:0] merge_lanes(input logic [15:0] old_v,
                                              input logic [15:0] wdata,
                                              input logic [1:0]  lane);
    logic [15:0] v;
    v = old_v;
    if (lane[0]) v[7:0]  = wdata[7:0];
    if (lane[1]) v[15:8] = wdata[15:8];
    return v;
  endfunction

endpackage

// File: rtl/fir_mac_core.sv
// Serial MAC engine: active coefficients, delay line, accumulator, saturation.
// Define FIR_ROUND_EN to round half up before the output shift (default: truncate).
//
// state | meaning
// IDLE  | waiting; a pending load wins over a pending sample
// LOAD  | copy one shadow coefficient per cycle into the active set
// SHIFT | push the new sample into the delay line, clear acc
// MAC   | one tap per cycle, acc += delay[k] * coeff[k]
// DONE  | register saturated result and err flag
module fir_mac_core
  import fir_ahb_pkg::*;
#(
  parameter int NUM_TAPS  = 4,
  parameter int OUT_SHIFT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_sample,
  input  logic                      start_load,
  input  logic [15:0]               sample_in,
  input  logic [NUM_TAPS-1:0][15:0] coeff_sh,
  output logic                      busy,
  output logic [15:0]               result,
  output logic                      err,
  output logic                      load_done
);

  localparam int ACC_W = acc_width(NUM_TAPS);
  localparam int CNT_W = $clog2(NUM_TAPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_TAPS - 1);

  fir_state_e state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic tc;
  logic sample_pend, load_pend;
  logic [NUM_TAPS-1:0][15:0] coeff_act;
  logic [NUM_TAPS-1:0][15:0] dly;
  logic signed [ACC_W-1:0] acc, acc_rnd, acc_sh;
  logic signed [15:0] tap_d, tap_c;
  logic signed [31:0] prod;
  logic sat_ovf;
  logic [15:0] sat_val;
  logic finishing;

  assign tc    = (cnt == '0);
  assign tap_d = dly[cnt];
  assign tap_c = coeff_act[cnt];
  assign prod  = 32'(tap_d) * 32'(tap_c);

`ifdef FIR_ROUND_EN
  assign acc_rnd = acc + (ACC_W'(1) <<< (OUT_SHIFT - 1));
`else
  assign acc_rnd = acc;
`endif
  assign acc_sh = acc_rnd >>> OUT_SHIFT;

  // Fits in 16 bits only if everything above bit 15 is a copy of the sign.
  assign sat_ovf = !((&acc_sh[ACC_W-1:15]) || !(|acc_sh[ACC_W-1:15]));
  assign sat_val = sat_ovf ? (acc_sh[ACC_W-1] ? 16'h8000 : 16'h7fff) : acc_sh[15:0];

  assign load_done = (state == LOAD) && tc;
  assign finishing = load_done || (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (load_pend)        state_nx = LOAD;
        else if (sample_pend) state_nx = SHIFT;
      end
      LOAD:    if (tc) state_nx = IDLE;
      SHIFT:   state_nx = MAC;
      MAC:     if (tc) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= CNT_LAST;
      sample_pend <= 1'b0;
      load_pend   <= 1'b0;
      busy        <= 1'b0;
      coeff_act   <= '0;
      dly         <= '0;
      acc         <= '0;
      result      <= '0;
      err         <= 1'b0;
    end else begin
      state <= state_nx;

      if (start_sample)                            sample_pend <= 1'b1;
      else if (state == IDLE && state_nx == SHIFT) sample_pend <= 1'b0;

      if (start_load)                             load_pend <= 1'b1;
      else if (state == IDLE && state_nx == LOAD) load_pend <= 1'b0;

      if (start_sample || start_load)                     busy <= 1'b1;
      else if (finishing && !sample_pend && !load_pend)   busy <= 1'b0;

      // Tap counter runs down to terminal count 0; reloaded whenever idle.
      if (state == LOAD || state == MAC) cnt <= cnt - CNT_W'(1);
      else                               cnt <= CNT_LAST;

      if (state == LOAD) coeff_act[cnt] <= coeff_sh[cnt];

      if (state == SHIFT) begin
        dly <= {dly[NUM_TAPS-2:0], sample_in};
        acc <= '0;
      end

      if (state == MAC) acc <= acc + ACC_W'(prod);

      if (state == DONE) begin
        result <= sat_val;
        err    <= sat_ovf;
      end
    end
  end

endmodule

// File: rtl/ahb_lite_fir_filter_param.sv
// AHB-lite leaf slave: zero-wait register file with shadow coefficients around fir_mac_core.
// FIR_ROUND_EN selects rounding inside the core; the bus side is identical in both builds.
module ahb_lite_fir_filter_param
  import fir_ahb_pkg::*;
#(
  parameter int NUM_TAPS  = 4,
  parameter int ADDR_W    = 6,
  parameter int OUT_SHIFT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hsize,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [15:0]       hwdata,
  output logic [15:0]       hrdata,
  output logic              hresp
);

  localparam int MAP_END = OFF_COEFF0 + 2 * NUM_TAPS;

  logic              ap_valid;
  logic              dp_valid, dp_write, dp_size;
  logic [ADDR_W-1:0] dp_addr;

  logic [15:0]               sample_q;
  logic                      confirm_q;
  logic [NUM_TAPS-1:0][15:0] coeff_sh;

  int          hoff, coeff_idx;
  logic        sel_status, sel_result, sel_sample, sel_confirm, sel_coeff;
  logic        in_map, misalign, bad, wr_ok;
  logic [1:0]  lane;
  logic [15:0] sample_d, conf_d, rd_data;
  logic        start_sample, start_load;

  logic        core_busy, core_err, load_done;
  logic [15:0] core_result;

  assign ap_valid = hsel && (htrans != HTRANS_IDLE) && (htrans != HTRANS_BUSY);

  always_comb begin
    hoff        = int'({dp_addr[ADDR_W-1:1], 1'b0});
    coeff_idx   = (hoff - OFF_COEFF0) >>> 1;
    sel_status  = (hoff == OFF_STATUS);
    sel_result  = (hoff == OFF_RESULT);
    sel_sample  = (hoff == OFF_SAMPLE);
    sel_confirm = (hoff == OFF_CONFIRM);
    sel_coeff   = (hoff >= OFF_COEFF0) && (hoff < MAP_END);
    in_map      = (hoff < MAP_END);
    misalign    = dp_size && dp_addr[0];
    lane        = dp_size ? 2'b11 : (dp_addr[0] ? 2'b10 : 2'b01);

    // A confirm_q of 1 means a coefficient load is pending or still copying.
    bad = !in_map || misalign
       || (dp_write && (sel_status || sel_result))
       || (dp_write && sel_sample && core_busy)
       || (dp_write && (sel_coeff || sel_confirm) && confirm_q);

    wr_ok        = dp_valid && dp_write && !bad;
    sample_d     = merge_lanes(sample_q, hwdata, lane);
    conf_d       = merge_lanes({15'b0, confirm_q}, hwdata, lane);
    start_sample = wr_ok && sel_sample;
    start_load   = wr_ok && sel_confirm && (conf_d != 16'h0000);
  end

  always_comb begin
    rd_data = '0;
    if (dp_valid && !dp_write && !bad) begin
      if (sel_status)  rd_data = {14'b0, core_err, core_busy};
      if (sel_result)  rd_data = core_result;
      if (sel_sample)  rd_data = sample_q;
      if (sel_confirm) rd_data = {15'b0, confirm_q};
      for (int k = 0; k < NUM_TAPS; k++) begin
        if (sel_coeff && coeff_idx == k) rd_data = coeff_sh[k];
      end
    end
  end

  assign hrdata = rd_data;
  assign hresp  = dp_valid && bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_size   <= 1'b0;
      dp_addr   <= '0;
      sample_q  <= '0;
      confirm_q <= 1'b0;
      coeff_sh  <= '0;
    end else begin
      dp_valid <= ap_valid;
      if (ap_valid) begin
        dp_addr  <= haddr;
        dp_write <= hwrite;
        dp_size  <= hsize;
      end

      if (start_sample) sample_q <= sample_d;

      if (load_done)       confirm_q <= 1'b0;
      else if (start_load) confirm_q <= 1'b1;

      for (int k = 0; k < NUM_TAPS; k++) begin
        if (wr_ok && sel_coeff && coeff_idx == k)
          coeff_sh[k] <= merge_lanes(coeff_sh[k], hwdata, lane);
      end
    end
  end

  fir_mac_core #(
    .NUM_TAPS  (NUM_TAPS),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_core (
    .clk          (clk),
    .rst          (rst),
    .start_sample (start_sample),
    .start_load   (start_load),
    .sample_in    (sample_q),
    .coeff_sh     (coeff_sh),
    .busy         (core_busy),
    .result       (core_result),
    .err          (core_err),
    .load_done    (load_done)
  );

endmodule

// File: tb/tb_ahb_lite_fir_filter_param.sv
// Scoreboard bench for ahb_lite_fir_filter_param (NUM_TAPS=4); honours FIR_ROUND_EN in its model.
module tb_ahb_lite_fir_filter_param;

  localparam int NT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [5:0]  haddr;
  logic        hsize;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [15:0] hwdata;
  logic [15:0] hrdata;
  logic        hresp;

  always #5 clk = ~clk;

  ahb_lite_fir_filter_param #(
    .NUM_TAPS  (NT),
    .ADDR_W    (6),
    .OUT_SHIFT (15)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .hsel   (hsel),
    .haddr  (haddr),
    .hsize  (hsize),
    .htrans (htrans),
    .hwrite (hwrite),
    .hwdata (hwdata),
    .hrdata (hrdata),
    .hresp  (hresp)
  );

  typedef struct {
    logic [15:0] rd;
    logic        resp;
    logic        chk_rd;
    logic [63:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic dp_tb   = 1'b0;
  logic [15:0] wd_nx = 16'h0;

  logic signed [15:0] m_coef [NT];
  logic signed [15:0] m_dly  [NT];
  logic [15:0] m_res;
  logic        m_err;

  task automatic chk(input logic [63:0] tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bus cycle: new address phase, plus hwdata for the previous transfer.
  task automatic bus(input logic [1:0] tr, input logic [5:0] a, input logic wr, input logic sz,
                     input logic [15:0] wd, input logic [15:0] erd, input logic eresp,
                     input logic [63:0] tag);
    exp_t e;
    @(posedge clk); #1;
    hwdata = wd_nx;
    hsel   = (tr != 2'b00);
    htrans = tr;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
    wd_nx  = wd;
    if (tr[1]) begin
      e.rd = erd; e.resp = eresp; e.chk_rd = !wr && !eresp; e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic wr16(input logic [5:0] a, input logic [15:0] d, input logic eresp, input logic [63:0] tag);
    bus(2'b10, a, 1'b1, 1'b1, d, 16'h0, eresp, tag);
  endtask

  task automatic rd16(input logic [5:0] a, input logic [15:0] erd, input logic [63:0] tag);
    bus(2'b10, a, 1'b0, 1'b1, 16'h0, erd, 1'b0, tag);
  endtask

  task automatic rd_err(input logic [5:0] a, input logic [63:0] tag);
    bus(2'b10, a, 1'b0, 1'b1, 16'h0, 16'h0, 1'b1, tag);
  endtask

  task automatic idle();
    bus(2'b00, 6'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "idle");
  endtask

  task automatic model_push(input logic [15:0] s);
    longint acc, sh;
    for (int i = NT - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
    m_dly[0] = s;
    acc = 0;
    for (int i = 0; i < NT; i++) acc += longint'(m_dly[i]) * longint'(m_coef[i]);
`ifdef FIR_ROUND_EN
    acc += 64'sd16384;
`endif
    sh = acc >>> 15;
    if (sh > 32767)       begin m_res = 16'h7fff; m_err = 1'b1; end
    else if (sh < -32768) begin m_res = 16'h8000; m_err = 1'b1; end
    else                  begin m_res = 16'(sh);  m_err = 1'b0; end
  endtask

  // Load confirm commits at call t+2's edge; copy finishes 5 cycles later.
  task automatic load_coefs(input logic [15:0] c);
    for (int k = 0; k < NT; k++) wr16(6'(8 + 2 * k), c, 1'b0, "ld_coef");
    rd16(6'hE, c, "ld_rdbk");
    wr16(6'h6, 16'h0001, 1'b0, "ld_conf");
    rd16(6'h6, 16'h0001, "ld_conf1");
    rd16(6'h0, {14'b0, m_err, 1'b1}, "ld_busy");
    wr16(6'h8, 16'h1111, 1'b1, "ld_c_rej");
    wr16(6'h6, 16'h0001, 1'b1, "ld_f_rej");
    rd16(6'h6, 16'h0001, "ld_conf_l");
    rd16(6'h6, 16'h0000, "ld_conf_c");
    rd16(6'h0, {14'b0, m_err, 1'b0}, "ld_idle");
    rd16(6'h8, c, "ld_shad");
    for (int k = 0; k < NT; k++) m_coef[k] = c;
  endtask

  // mode 0: plain; 1: back-to-back sample write rejected; 2: readback then misaligned write.
  task automatic sample_run(input logic [5:0] a, input logic sz, input logic [15:0] wd,
                            input logic [15:0] sval, input int mode);
    logic [15:0] p_res;
    logic        p_err;
    p_res = m_res;
    p_err = m_err;
    model_push(sval);
    bus(2'b10, a, 1'b1, sz, wd, 16'h0, 1'b0, "s_write");
    if (mode == 1) wr16(6'h4, 16'd9, 1'b1, "s_rej");
    else if (mode == 2) rd16(6'h4, sval, "s_rdbk");
    else idle();
    if (mode == 2) wr16(6'h5, 16'h1111, 1'b1, "s_misal");
    else idle();
    repeat (3) idle();
    rd16(6'h0, {14'b0, p_err, 1'b1}, "s_busy");
    rd16(6'h2, p_res, "s_done_cy");
    rd16(6'h2, m_res, "s_result");
    rd16(6'h0, {14'b0, m_err, 1'b0}, "s_status");
  endtask

  always @(posedge clk) dp_tb <= hsel && htrans[1];

  always @(negedge clk) begin
    if (dp_tb) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk(mon_e.tag, 32'(hresp), 32'(mon_e.resp));
        if (mon_e.chk_rd) chk(mon_e.tag, 32'(hrdata), 32'(mon_e.rd));
      end
    end else if (!rst) begin
      chk("no_dphase", 32'(hresp), 32'd0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; hsel = 1'b0; haddr = '0; hsize = 1'b0; htrans = 2'b00;
    hwrite = 1'b0; hwdata = '0;
    m_res = '0; m_err = 1'b0;
    for (int i = 0; i < NT; i++) begin m_coef[i] = '0; m_dly[i] = '0; end

    @(posedge clk); #1;
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", 32'(hrdata), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // reset values
    rd16(6'h0, 16'h0000, "t1_stat");
    rd16(6'h2, 16'h0000, "t1_res");
    rd16(6'h4, 16'h0000, "t1_samp");
    rd16(6'h6, 16'h0000, "t1_conf");
    rd16(6'h8, 16'h0000, "t1_coef0");

    // 0.5 coefficients, running sums 50/150/300/500
    load_coefs(16'h4000);
    sample_run(6'h4, 1'b1, 16'd100, 16'd100, 0);
    sample_run(6'h4, 1'b1, 16'd200, 16'd200, 0);
    sample_run(6'h4, 1'b1, 16'd300, 16'd300, 0);
    sample_run(6'h4, 1'b1, 16'd400, 16'd400, 0);

    // error responses and non-transfers leave state untouched
    wr16(6'h2, 16'h5555, 1'b1, "t3_wres");
    rd_err(6'h3C, "t3_oob");
    wr16(6'h0, 16'hffff, 1'b1, "t3_wstat");
    rd_err(6'h10, "t3_oobedge");
    rd16(6'hE, 16'h4000, "t3_coef3");
    bus(2'b01, 6'h2, 1'b1, 1'b1, 16'hdead, 16'h0, 1'b0, "t3_busytr");
    wr16(6'h6, 16'h0000, 1'b0, "t3_conf0");
    rd16(6'h6, 16'h0000, "t3_conf0r");
    rd16(6'h2, m_res, "t3_res");
    rd16(6'h0, {14'b0, m_err, 1'b0}, "t3_stat");

    // second sample while busy is rejected
    sample_run(6'h4, 1'b1, 16'd7, 16'd7, 1);
    rd16(6'h4, 16'd7, "t4_samp");

    // saturation then recovery
    load_coefs(16'h7fff);
    repeat (4) sample_run(6'h4, 1'b1, 16'h7fff, 16'h7fff, 0);
    load_coefs(16'h0000);
    sample_run(6'h4, 1'b1, 16'd1, 16'd1, 0);

    // byte lane write and misaligned halfword
    sample_run(6'h4, 1'b1, 16'h0000, 16'h0000, 0);
    sample_run(6'h5, 1'b0, 16'h12AB, 16'h1200, 2);
    rd16(6'h4, 16'h1200, "t6_samp2");
    bus(2'b10, 6'h5, 1'b0, 1'b0, 16'h0, 16'h1200, 1'b0, "t6_brd");

    repeat (3) idle();
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
